// File: rtl/output_requantizer_pkg.sv
// -----------------------------------------------------------------------------
// output_requantizer_pkg
//   Shared definitions for the output requantizer slice: default widths, FSM
//   state encodings, saturation limits and the requantize function used on the
//   capture path.
//
//   Build option: OUTPUT_REQUANTIZER_ROUND_EN
//     defined   -> round-half-up (add 2^(SHIFT-1) before the arithmetic shift)
//     undefined -> truncation (floor), no adder in the path
// -----------------------------------------------------------------------------
package output_requantizer_pkg;

    localparam int unsigned DWIDTH_DEF  = 16;
    localparam int unsigned DDWIDTH_DEF = 2 * DWIDTH_DEF;
    localparam int unsigned SHIFT_DEF   = 15;

    // Requantize arithmetic is done at a fixed wide width so one function
    // serves any legal parameter set; constant arguments let synthesis trim
    // the unused upper bits, which are pure sign copies.
    localparam int unsigned CALC_W = 64;
    localparam logic signed [CALC_W-1:0] ONE = 1;

    typedef enum logic {
        I_IDLE,
        I_ACK
    } in_state_e;

    typedef enum logic [1:0] {
        O_IDLE,
        O_REQ,
        O_WAIT
    } out_state_e;

    typedef struct packed {
        logic                     sat;
        logic signed [CALC_W-1:0] value;
    } rq_result_t;

    // Saturation limits of a signed dwidth-bit result: 2^(w-1)-1 and -2^(w-1).
    function automatic logic signed [CALC_W-1:0] sat_max(input int unsigned dwidth);
        return (ONE <<< (dwidth - 1)) - ONE;
    endfunction

    function automatic logic signed [CALC_W-1:0] sat_min(input int unsigned dwidth);
        return -(ONE <<< (dwidth - 1));
    endfunction

    // x must already be sign-extended to CALC_W bits.
    function automatic rq_result_t requantize(input logic signed [CALC_W-1:0] x,
                                              input int unsigned              shift,
                                              input int unsigned              dwidth);
        rq_result_t               res;
        logic signed [CALC_W-1:0] r;
`ifdef OUTPUT_REQUANTIZER_ROUND_EN
        logic signed [CALC_W-1:0] half;
        half = ONE <<< (shift - 1);
        r    = (x + half) >>> shift;
`else
        r    = x >>> shift;
`endif
        if (r > sat_max(dwidth)) begin
            res.sat   = 1'b1;
            res.value = sat_max(dwidth);
        end else if (r < sat_min(dwidth)) begin
            res.sat   = 1'b1;
            res.value = sat_min(dwidth);
        end else begin
            res.sat   = 1'b0;
            res.value = r;
        end
        return res;
    endfunction

endpackage

// File: rtl/output_requantizer_if.sv
// -----------------------------------------------------------------------------
// output_requantizer_if
//   Both 4-phase req/ack handshakes of the requantizer plus its status outputs.
//   Vectors are declared [0:N-1] so bit 0 is the MSB.
//
//   master : the environment (filter producer + sink)
//   slave  : output_requantizer
//     req_in/data_in  -> sample from the filter, data stable while req_in high
//     ack_in          <- sample accepted
//     req_out         <- data_out/sat_flag valid for the sink
//     ack_out         -> sink has taken data_out
//     level           <- FIFO occupancy 0..DEPTH
// -----------------------------------------------------------------------------
interface output_requantizer_if
    import output_requantizer_pkg::*;
#(
    parameter int unsigned DWIDTH  = DWIDTH_DEF,
    parameter int unsigned DDWIDTH = 2 * DWIDTH,
    parameter int unsigned AWIDTH  = 2
);
    logic               req_in;
    logic               ack_in;
    logic [0:DDWIDTH-1] data_in;
    logic               req_out;
    logic               ack_out;
    logic [0:DWIDTH-1]  data_out;
    logic               sat_flag;
    logic [AWIDTH:0]    level;

    modport master (
        output req_in, data_in, ack_out,
        input  ack_in, req_out, data_out, sat_flag, level
    );

    modport slave (
        input  req_in, data_in, ack_out,
        output ack_in, req_out, data_out, sat_flag, level
    );
endinterface

// File: rtl/output_requantizer_sample_fifo.sv
// -----------------------------------------------------------------------------
// sample_fifo
//   Synchronous FIFO, DEPTH entries of WIDTH bits (DEPTH a power of two).
//   rdata shows the head entry combinationally; pop advances past it.
//   Simultaneous push and pop leave level unchanged. full/empty are derived
//   from level. Callers never push when full nor pop when empty.
//
//   clk, rst (sync, active-high)
//   push, wdata   -> write at tail
//   pop, rdata    -> head entry / advance head
//   full, empty, level
// -----------------------------------------------------------------------------
module sample_fifo #(
    parameter int unsigned WIDTH  = 17,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned AWIDTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              pop,
    output logic [WIDTH-1:0]  rdata,
    output logic              full,
    output logic              empty,
    output logic [AWIDTH:0]   level
);
    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [AWIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [AWIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [AWIDTH:0]   level_q, level_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        // Pointers are AWIDTH bits wide, so the increment wraps modulo DEPTH.
        if (push) wr_ptr_d = wr_ptr_q + AWIDTH'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AWIDTH'(1);
        case ({push, pop})
            2'b10:   level_d = level_q + (AWIDTH+1)'(1);
            2'b01:   level_d = level_q - (AWIDTH+1)'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // NOTE: storage is deliberately not reset; level==0 already marks every
    // entry invalid, and leaving it out keeps the array as plain RAM.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign level = level_q;
    assign full  = (level_q == (AWIDTH+1)'(DEPTH));
    assign empty = (level_q == '0);

endmodule

// File: rtl/output_requantizer.sv
// -----------------------------------------------------------------------------
// output_requantizer
//   Accepts DDWIDTH-bit accumulator samples from the FIR stage over a 4-phase
//   req/ack handshake, shifts right by SHIFT, saturates to DWIDTH bits, buffers
//   the result (plus its saturation bit) in a DEPTH-entry FIFO and offers it to
//   the sink over a second 4-phase handshake.
//
//   Ports: clk, rst (sync, active-high), bus (output_requantizer_if.slave:
//   req_in/ack_in/data_in, req_out/ack_out/data_out/sat_flag, level).
//
//   Build option: OUTPUT_REQUANTIZER_ROUND_EN selects round-half-up instead of
//   truncation; saturation, ports and timing are the same in both builds.
// -----------------------------------------------------------------------------
module output_requantizer
    import output_requantizer_pkg::*;
#(
    parameter int unsigned DWIDTH  = DWIDTH_DEF,
    parameter int unsigned DDWIDTH = 2 * DWIDTH,
    parameter int unsigned SHIFT   = SHIFT_DEF,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned AWIDTH  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    output_requantizer_if.slave  bus
);
    // ---------------- capture path ----------------
    logic signed [DDWIDTH-1:0] sample_in;
    logic signed [CALC_W-1:0]  sample_ext;
    rq_result_t                rq;
    logic [DWIDTH:0]           fifo_wdata;
    logic                      unused_rq_hi;

    // [0:N-1] and [N-1:0] vectors share numeric value; only the index names differ.
    assign sample_in  = bus.data_in;
    assign sample_ext = {{(CALC_W-DDWIDTH){sample_in[DDWIDTH-1]}}, sample_in};
    assign rq         = requantize(sample_ext, SHIFT, DWIDTH);
    assign fifo_wdata = {rq.sat, rq.value[DWIDTH-1:0]};
    // After clipping, the bits above DWIDTH only repeat the sign.
    assign unused_rq_hi = ^rq.value[CALC_W-1:DWIDTH];

    // ---------------- FIFO ----------------
    logic              push, pop;
    logic [DWIDTH:0]   fifo_rdata;
    logic              fifo_full, fifo_empty;
    logic [AWIDTH:0]   fifo_level;

    sample_fifo #(
        .WIDTH  (DWIDTH + 1),
        .DEPTH  (DEPTH),
        .AWIDTH (AWIDTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (fifo_wdata),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // ---------------- input FSM ----------------
    in_state_e in_state_q, in_state_d;
    logic      ack_in_q, ack_in_d;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        in_state_d = in_state_q;
        ack_in_d   = ack_in_q;
        push       = 1'b0;
        case (in_state_q)
            I_IDLE: begin
                // Full is judged on this cycle's level: a pop at the same
                // edge only frees the slot for the next cycle.
                if (bus.req_in && !fifo_full) begin
                    push       = 1'b1;
                    ack_in_d   = 1'b1;
                    in_state_d = I_ACK;
                end
            end
            I_ACK: begin
                if (!bus.req_in) begin
                    ack_in_d   = 1'b0;
                    in_state_d = I_IDLE;
                end
            end
            default: begin
                ack_in_d   = 1'b0;
                in_state_d = I_IDLE;
            end
        endcase
    end

    // ---------------- output FSM ----------------
    out_state_e        out_state_q, out_state_d;
    logic              req_out_q, req_out_d;
    logic [DWIDTH-1:0] data_out_q, data_out_d;
    logic              sat_q, sat_d;

    always_comb begin
        out_state_d = out_state_q;
        req_out_d   = req_out_q;
        data_out_d  = data_out_q;
        sat_d       = sat_q;
        pop         = 1'b0;
        case (out_state_q)
            O_IDLE: begin
                if (!fifo_empty) begin
                    pop                 = 1'b1;
                    {sat_d, data_out_d} = fifo_rdata;
                    req_out_d           = 1'b1;
                    out_state_d         = O_REQ;
                end
            end
            O_REQ: begin
                if (bus.ack_out) begin
                    req_out_d   = 1'b0;
                    out_state_d = O_WAIT;
                end
            end
            O_WAIT: begin
                if (!bus.ack_out) out_state_d = O_IDLE;
            end
            default: begin
                req_out_d   = 1'b0;
                out_state_d = O_IDLE;
            end
        endcase
    end

    // ---------------- state registers ----------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_state_q  <= I_IDLE;
            ack_in_q    <= 1'b0;
            out_state_q <= O_IDLE;
            req_out_q   <= 1'b0;
            data_out_q  <= '0;
            sat_q       <= 1'b0;
        end else begin
            in_state_q  <= in_state_d;
            ack_in_q    <= ack_in_d;
            out_state_q <= out_state_d;
            req_out_q   <= req_out_d;
            data_out_q  <= data_out_d;
            sat_q       <= sat_d;
        end
    end

    assign bus.ack_in   = ack_in_q;
    assign bus.req_out  = req_out_q;
    assign bus.data_out = data_out_q;
    assign bus.sat_flag = sat_q;
    assign bus.level    = fifo_level;

endmodule
